// File: rtl/ropuf_key_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ropuf_key_sequencer: ring-oscillator PUF key-generation sequencer.         |
// | Optional tie-flag output enabled by macro ROPUF_TIE_FLAG_EN.               |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module ropuf_key_sequencer #(
  parameter int unsigned KEY_BITS = 16,
  parameter logic [7:0]  WINDOW   = 8'd240,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                clk,
  input  logic                Reset,
  input  logic                start,
  input  logic [15:0]         challenge,
  input  logic [CNT_W-1:0]    ro_cnt_a,
  input  logic [CNT_W-1:0]    ro_cnt_b,
  output logic [3:0]          sel_a,
  output logic [3:0]          sel_b,
  output logic                ro_clr,
  output logic                ro_en,
  output logic [7:0]          round,
  output logic                busy,
  output logic [KEY_BITS-1:0] key,
`ifdef ROPUF_TIE_FLAG_EN
  output logic [KEY_BITS-1:0] tie_mask,
`endif
  output logic                key_valid
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD    = 3'd1;
  localparam logic [2:0] S_CLEAR   = 3'd2;
  localparam logic [2:0] S_MEASURE = 3'd3;
  localparam logic [2:0] S_COMPARE = 3'd4;
  localparam logic [2:0] S_ROTATE  = 3'd5;
  localparam logic [2:0] S_DONE    = 3'd6;

  localparam logic [7:0] C_ROUND_LAST  = 8'(KEY_BITS - 1);
  localparam logic [7:0] C_WINDOW_LAST = WINDOW - 8'd1;

  // Pair select: B is bumped by one (mod 16) so A and B never name the same RO.
  function automatic logic [7:0] pair_sel(input logic [15:0] c);
    logic [3:0] a;
    logic [3:0] b;
    a = c[15:12];
    b = c[11:8];
    if (a == b) begin
      b = b + 4'd1;
    end
    return {a, b};
  endfunction

  logic [2:0]          state_q, state_d;
  logic                start_q;
  logic [15:0]         req_chal_q;
  logic [15:0]         chal_q, chal_d;
  logic [7:0]          win_q, win_d;
  logic [7:0]          round_q, round_d;
  logic [KEY_BITS-1:0] key_q, key_d;
  logic [7:0]          sel_q, sel_d;
  logic                ro_clr_q;
  logic                ro_en_q;
  logic                busy_q;
  logic                key_valid_q;

  logic                cnt_gt;
  logic [15:0]         chal_rot;

  assign cnt_gt   = (ro_cnt_a > ro_cnt_b);
  assign chal_rot = {chal_q[0], chal_q[15:1]};

  always_comb begin
    state_d = state_q;
    chal_d  = chal_q;
    win_d   = win_q;
    round_d = round_q;
    key_d   = key_q;
    sel_d   = sel_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_q) begin
          state_d = S_LOAD;
          chal_d  = req_chal_q;
          round_d = 8'd0;
          key_d   = '0;
          sel_d   = pair_sel(req_chal_q);
        end
      end
      S_LOAD: begin
        state_d = S_CLEAR;
      end
      S_CLEAR: begin
        state_d = S_MEASURE;
        win_d   = 8'd0;
      end
      S_MEASURE: begin
        if (win_q == C_WINDOW_LAST) begin
          state_d = S_COMPARE;
        end else begin
          win_d = win_q + 8'd1;
        end
      end
      S_COMPARE: begin
        key_d = {key_q[KEY_BITS-2:0], cnt_gt};
        if (round_q == C_ROUND_LAST) begin
          state_d = S_DONE;
        end else begin
          state_d = S_ROTATE;
          chal_d  = chal_rot;
          round_d = round_q + 8'd1;
          sel_d   = pair_sel(chal_rot);
        end
      end
      S_ROTATE: begin
        state_d = S_CLEAR;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // start and challenge are captured together so the challenge seen is the
  // one present on the start-sampling edge.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      start_q    <= 1'b0;
      req_chal_q <= 16'd0;
    end else begin
      start_q <= start;
      if (start) begin
        req_chal_q <= challenge;
      end
    end
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= S_IDLE;
      chal_q      <= 16'd0;
      win_q       <= 8'd0;
      round_q     <= 8'd0;
      key_q       <= '0;
      sel_q       <= 8'd0;
      ro_clr_q    <= 1'b0;
      ro_en_q     <= 1'b0;
      busy_q      <= 1'b0;
      key_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      chal_q      <= chal_d;
      win_q       <= win_d;
      round_q     <= round_d;
      key_q       <= key_d;
      sel_q       <= sel_d;
      ro_clr_q    <= (state_d == S_CLEAR);
      ro_en_q     <= (state_d == S_MEASURE);
      busy_q      <= (state_d != S_IDLE) && (state_d != S_DONE);
      key_valid_q <= (state_d == S_DONE);
    end
  end

`ifdef ROPUF_TIE_FLAG_EN
  logic [KEY_BITS-1:0] tie_q, tie_d;

  always_comb begin
    tie_d = tie_q;
    if ((state_q == S_IDLE || state_q == S_DONE) && start_q) begin
      tie_d = '0;
    end else if (state_q == S_COMPARE) begin
      tie_d = {tie_q[KEY_BITS-2:0], (ro_cnt_a == ro_cnt_b)};
    end
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      tie_q <= '0;
    end else begin
      tie_q <= tie_d;
    end
  end

  assign tie_mask = tie_q;
`endif

  assign sel_a     = sel_q[7:4];
  assign sel_b     = sel_q[3:0];
  assign ro_clr    = ro_clr_q;
  assign ro_en     = ro_en_q;
  assign round     = round_q;
  assign busy      = busy_q;
  assign key       = key_q;
  assign key_valid = key_valid_q;

endmodule
`default_nettype wire
